// File: rtl/life_pkg.sv
// Shared types and defaults for the player lives counter.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ALIVE     = 2'd1,
        INVULN    = 2'd2,
        GAME_OVER = 2'd3
    } life_state_t;

    localparam int unsigned DEFAULT_LIVES_W      = 3;
    localparam int unsigned DEFAULT_START_LIVES  = 3;
    localparam int unsigned DEFAULT_MAX_LIVES    = 7;
    localparam int unsigned DEFAULT_INVULN_TICKS = 60;

    // Counter width able to hold the full cooldown load value.
    function automatic int unsigned cooldown_width(input int unsigned ticks);
        return $clog2(ticks + 1);
    endfunction

endpackage

// File: rtl/cooldown_timer.sv
// Loadable down-counter advanced by enable ticks; flags the final tick
// combinationally and as a registered expire pulse.
module cooldown_timer
    import life_pkg::*;
#(
    parameter int unsigned TICKS = DEFAULT_INVULN_TICKS,
    parameter int unsigned CNT_W = cooldown_width(TICKS)
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic load,
    input  logic tick,
    output logic final_c,
    output logic expire
);

    logic [CNT_W-1:0] count;

    always_comb begin
        final_c = tick && (count == CNT_W'(1));
    end

    // Clear beats load so a restart always leaves the timer idle.
    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            count  <= '0;
            expire <= 1'b0;
        end else begin
            expire <= final_c;
            if (load) begin
                count <= CNT_W'(TICKS);
            end else if (tick && (count != '0)) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/life_counter.sv
// Player lives tracker: start/restart, hit handling with a frame-timed
// invulnerability window, and game-over. Optional bonus lives: EXTRA_LIFE_EN.
module life_counter
    import life_pkg::*;
#(
    parameter int unsigned LIVES_W      = DEFAULT_LIVES_W,
    parameter int unsigned START_LIVES  = DEFAULT_START_LIVES,
    parameter int unsigned MAX_LIVES    = DEFAULT_MAX_LIVES,
    parameter int unsigned INVULN_TICKS = DEFAULT_INVULN_TICKS
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start,
    input  logic               hit,
    input  logic               frame_tick,
`ifdef EXTRA_LIFE_EN
    input  logic               bonus,
`endif
    output logic [LIVES_W-1:0] lives,
    output logic               invulnerable,
    output logic               game_over,
    output logic               hit_ack
);

    localparam int unsigned START_CLAMP = (START_LIVES > MAX_LIVES) ? MAX_LIVES : START_LIVES;
    localparam logic [LIVES_W-1:0] LIVES_START = LIVES_W'(START_CLAMP);
    localparam logic [LIVES_W-1:0] LIVES_ONE   = LIVES_W'(1);

    life_state_t      state;
    logic             in_game;
    logic             hit_fatal;
    logic [LIVES_W-1:0] hit_base;
    logic             cd_clear;
    logic             cd_load;
    logic             cd_tick;
    logic             cd_final_c;
    logic             cd_expire;

`ifdef EXTRA_LIFE_EN
    localparam logic [LIVES_W-1:0] LIVES_MAX = LIVES_W'(MAX_LIVES);
    logic             bonus_en;
    logic [LIVES_W-1:0] lives_inc;
`endif

    // Lives seen by a hit; a same-cycle bonus is credited before the hit.
    always_comb begin
        in_game = (state == ALIVE) || (state == INVULN);
`ifdef EXTRA_LIFE_EN
        bonus_en  = bonus && in_game;
        lives_inc = (lives >= LIVES_MAX) ? LIVES_MAX : lives + LIVES_ONE;
        hit_base  = bonus_en ? lives_inc : lives;
`else
        hit_base  = lives;
`endif
        hit_fatal = (hit_base <= LIVES_ONE);
    end

    always_comb begin
        cd_clear = start && in_game;
        cd_load  = (state == ALIVE) && !start && hit && !hit_fatal;
        cd_tick  = (state == INVULN) && frame_tick;
    end

    cooldown_timer #(
        .TICKS (INVULN_TICKS)
    ) u_cooldown (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear   (cd_clear),
        .load    (cd_load),
        .tick    (cd_tick),
        .final_c (cd_final_c),
        .expire  (cd_expire)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            lives        <= LIVES_START;
            invulnerable <= 1'b0;
            game_over    <= 1'b0;
            hit_ack      <= 1'b0;
        end else begin
            hit_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ALIVE;
                        lives <= LIVES_START;
                    end
                end
                ALIVE: begin
                    if (start) begin
                        lives <= LIVES_START;
                    end else if (hit) begin
                        hit_ack <= 1'b1;
                        if (hit_fatal) begin
                            state     <= GAME_OVER;
                            lives     <= '0;
                            game_over <= 1'b1;
                        end else begin
                            state        <= INVULN;
                            lives        <= hit_base - LIVES_ONE;
                            invulnerable <= 1'b1;
                        end
`ifdef EXTRA_LIFE_EN
                    end else if (bonus_en) begin
                        lives <= lives_inc;
`endif
                    end
                end
                INVULN: begin
                    if (start) begin
                        state        <= ALIVE;
                        lives        <= LIVES_START;
                        invulnerable <= 1'b0;
                    end else begin
`ifdef EXTRA_LIFE_EN
                        if (bonus_en) begin
                            lives <= lives_inc;
                        end
`endif
                        if (cd_final_c) begin
                            state        <= ALIVE;
                            invulnerable <= 1'b0;
                        end
                    end
                end
                GAME_OVER: begin
                    lives <= '0;
                    if (start) begin
                        state     <= ALIVE;
                        lives     <= LIVES_START;
                        game_over <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    lives        <= LIVES_START;
                    invulnerable <= 1'b0;
                    game_over    <= 1'b0;
                end
            endcase
        end
    end

    // The timer only expires on the tick that returns the FSM to ALIVE.
    expire_tracks_state: assert property (@(posedge Clk) disable iff (Reset)
        cd_expire |-> (state == ALIVE && !invulnerable));

endmodule

// File: tb/tb_life_counter.sv
// Directed self-checking bench for life_counter (default parameters).
module tb_life_counter;
    import life_pkg::*;

    logic       Clk;
    logic       Reset;
    logic       start;
    logic       hit;
    logic       frame_tick;
    logic       bonus;
    logic [2:0] lives;
    logic       invulnerable;
    logic       game_over;
    logic       hit_ack;

    int checks = 0;
    int errors = 0;
    int ack_cnt;
    int drop_cnt;

    life_counter dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .start        (start),
        .hit          (hit),
        .frame_tick   (frame_tick),
`ifdef EXTRA_LIFE_EN
        .bonus        (bonus),
`endif
        .lives        (lives),
        .invulnerable (invulnerable),
        .game_over    (game_over),
        .hit_ack      (hit_ack)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_out(input string tag, input int l, input int inv, input int go, input int ack);
        chk({tag, ".lives"}, 32'(lives), 32'(l));
        chk({tag, ".invulnerable"}, 32'(invulnerable), 32'(inv));
        chk({tag, ".game_over"}, 32'(game_over), 32'(go));
        chk({tag, ".hit_ack"}, 32'(hit_ack), 32'(ack));
    endtask

    task automatic cool(input int n);
        frame_tick = 1'b1;
        for (int i = 0; i < n; i++) step();
        frame_tick = 1'b0;
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        step();
        hit = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; hit = 1'b0; frame_tick = 1'b0; bonus = 1'b0;
        step();
        step();
        Reset = 1'b0;
        chk_out("reset", 3, 0, 0, 0);
        chk("reset_state", 32'(dut.state), 32'(IDLE));

        // hit and frame_tick in IDLE are ignored
        hit = 1'b1; frame_tick = 1'b1;
        step();
        hit = 1'b0; frame_tick = 1'b0;
        chk_out("idle_hit", 3, 0, 0, 0);

        start = 1'b1;
        step();
        start = 1'b0;
        chk_out("start", 3, 0, 0, 0);

        pulse_hit();
        chk_out("hit1", 2, 1, 0, 1);

        // 59 ticks spread over 118 cycles with hit held high
        ack_cnt = 0; drop_cnt = 0;
        hit = 1'b1;
        for (int i = 0; i < 118; i++) begin
            frame_tick = (i % 2 == 0);
            step();
            if (hit_ack) ack_cnt++;
            if (!invulnerable) drop_cnt++;
        end
        chk("invuln_no_ack", 32'(ack_cnt), 32'd0);
        chk("invuln_held", 32'(drop_cnt), 32'd0);
        chk("invuln_lives", 32'(lives), 32'd2);
        frame_tick = 1'b1;
        step();
        hit = 1'b0; frame_tick = 1'b0;
        chk_out("tick60", 2, 0, 0, 0);

        // start beats hit in the same cycle
        hit = 1'b1; start = 1'b1;
        step();
        hit = 1'b0; start = 1'b0;
        chk_out("start_and_hit", 3, 0, 0, 0);
        chk("start_and_hit_state", 32'(dut.state), 32'(ALIVE));

        pulse_hit();
        chk_out("go_hit1", 2, 1, 0, 1);
        cool(60);
        chk_out("go_cool1", 2, 0, 0, 0);
        pulse_hit();
        chk_out("go_hit2", 1, 1, 0, 1);
        cool(60);
        pulse_hit();
        chk_out("go_hit3", 0, 0, 1, 1);
        hit = 1'b1; frame_tick = 1'b1;
        step();
        step();
        hit = 1'b0; frame_tick = 1'b0;
        chk_out("go_hold", 0, 0, 1, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_out("go_restart", 3, 0, 0, 0);

        // restart mid-window must clear the cooldown; next window is full length
        pulse_hit();
        cool(10);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_out("invuln_restart", 3, 0, 0, 0);
        pulse_hit();
        chk_out("after_restart_hit", 2, 1, 0, 1);
        cool(59);
        chk("full_window_59", 32'(invulnerable), 32'd1);
        cool(1);
        chk("full_window_60", 32'(invulnerable), 32'd0);

        // reset in the middle of INVULN with 30 ticks left
        start = 1'b1;
        step();
        start = 1'b0;
        pulse_hit();
        cool(30);
        chk("mid_invuln", 32'(invulnerable), 32'd1);
        Reset = 1'b1; hit = 1'b1; start = 1'b1;
        step();
        Reset = 1'b0; start = 1'b0;
        chk_out("reset_mid", 3, 0, 0, 0);
        chk("reset_mid_state", 32'(dut.state), 32'(IDLE));
        step();
        hit = 1'b0;
        chk_out("reset_then_hit", 3, 0, 0, 0);

`ifdef EXTRA_LIFE_EN
        bonus = 1'b1;
        step();
        bonus = 1'b0;
        chk("bonus_idle", 32'(lives), 32'd3);
        start = 1'b1;
        step();
        start = 1'b0;
        bonus = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("bonus_to_7", 32'(lives), 32'd7);
        step();
        bonus = 1'b0;
        chk("bonus_sat", 32'(lives), 32'd7);
        start = 1'b1;
        step();
        start = 1'b0;
        pulse_hit();
        cool(60);
        pulse_hit();
        cool(60);
        chk("bonus_pre", 32'(lives), 32'd1);
        hit = 1'b1; bonus = 1'b1;
        step();
        hit = 1'b0; bonus = 1'b0;
        chk_out("bonus_hit", 1, 1, 0, 1);
        bonus = 1'b1;
        step();
        bonus = 1'b0;
        chk_out("bonus_invuln", 2, 1, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
